// File: rtl/meduram_pkg.sv
// Shared definitions for the multi-bank RAM bookkeeping blocks.
package meduram_pkg;

    // Selects which agent wins when several writers hit the same row.
    localparam int COLLISION_LOWEST  = 0;
    localparam int COLLISION_HIGHEST = 1;

    // Accounter sequencing: normal operation, or a row-by-row table wipe.
    typedef enum logic {
        IDLE,
        SWEEP
    } acc_state_e;

endpackage

// File: rtl/accounter_mp_if.sv
// Write-agent / read-agent bus of the accounter.
// The master side drives requests and the slave side returns responses.
interface accounter_mp_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int NB_WRAGENT   = 4,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
);
    logic                               clear;
    logic                               busy;
    logic [NB_WRAGENT-1:0]              wren;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr;
    logic [NB_RDAGENT-1:0]              rden;
    logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr;
    logic [NB_RDAGENT-1:0]              rdvalid;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect;
    logic [NB_RDAGENT-1:0]              rdwritten;
    logic                               wrcollision;

    modport master (
        output clear, wren, wraddr, rden, rdaddr,
        input  busy, rdvalid, rdselect, rdwritten, wrcollision
    );

    modport slave (
        input  clear, wren, wraddr, rden, rdaddr,
        output busy, rdvalid, rdselect, rdwritten, wrcollision
    );
endinterface

// File: rtl/accounter_wrprio.sv
// Per-row write arbitration: tells whether any enabled writer targets this
// row, which writer wins, and whether two or more writers target it.
module accounter_wrprio
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int NB_WRAGENT     = 4,
    parameter int SELECT_WIDTH   = 2,
    parameter int COLLISION_MODE = COLLISION_LOWEST,
    parameter int ROW            = 0
) (
    input  logic [NB_WRAGENT-1:0]            wren_i,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr_i,
    output logic                             hit_o,
    output logic [SELECT_WIDTH-1:0]          winner_o,
    output logic                             collision_o
);
    localparam logic [ADDR_WIDTH-1:0] ROW_ADDR = ADDR_WIDTH'(ROW);

    logic [NB_WRAGENT-1:0] match;

    // Agents whose enabled write targets this row.
    always_comb begin
        match = '0;
        for (int a = 0; a < NB_WRAGENT; a++) begin
            match[a] = wren_i[a] && (wraddr_i[a*ADDR_WIDTH +: ADDR_WIDTH] == ROW_ADDR);
        end
    end

    // Winner selection; the last assignment in scan order takes effect.
    // Clearing the lowest set bit leaves something only if two or more matched.
    always_comb begin
        winner_o    = '0;
        hit_o       = |match;
        collision_o = |(match & (match - NB_WRAGENT'(1)));
        if (COLLISION_MODE == COLLISION_HIGHEST) begin
            for (int a = 0; a < NB_WRAGENT; a++) begin
                if (match[a]) winner_o = SELECT_WIDTH'(a);
            end
        end else begin
            for (int a = NB_WRAGENT - 1; a >= 0; a--) begin
                if (match[a]) winner_o = SELECT_WIDTH'(a);
            end
        end
    end
endmodule

// File: rtl/accounter_mp.sv
// Multi-port write-agent accounter: tracks the last writer of every row,
// answers per-read-agent lookups one cycle later, flags write collisions
// and wipes the table row by row on clear.
//
// state | meaning
// IDLE  | normal operation, writes update the table
// SWEEP | one row wiped per cycle, writes dropped, reads report unwritten
module accounter_mp
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_DEPTH      = 2**ADDR_WIDTH,
    parameter int NB_WRAGENT     = 4,
    parameter int NB_RDAGENT     = 2,
    parameter int SELECT_WIDTH   = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
    parameter int COLLISION_MODE = COLLISION_LOWEST,
    parameter int BYPASS         = 1
) (
    input logic           aclk,
    input logic           areset,
    accounter_mp_if.slave bus
);
    typedef struct packed {
        logic                    written;
        logic [SELECT_WIDTH-1:0] owner;
    } entry_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(RAM_DEPTH - 1);

    acc_state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]              cnt_q, cnt_d;
    entry_t                             entry_q [RAM_DEPTH];

    logic [NB_WRAGENT-1:0]              wren_eff;
    logic [RAM_DEPTH-1:0]               hit_w;
    logic [RAM_DEPTH-1:0]               coll_w;
    logic [SELECT_WIDTH-1:0]            winner_w [RAM_DEPTH];

    logic                               wrcoll_q;
    logic [NB_RDAGENT-1:0]              rdvalid_q;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect_q, rdselect_d;
    logic [NB_RDAGENT-1:0]              rdwritten_q, rdwritten_d;

    // Writes are dropped while the sweep owns the table.
    assign wren_eff = (state_q == IDLE) ? bus.wren : '0;

    for (genvar k = 0; k < RAM_DEPTH; k++) begin : g_row
        accounter_wrprio #(
            .ADDR_WIDTH     (ADDR_WIDTH),
            .NB_WRAGENT     (NB_WRAGENT),
            .SELECT_WIDTH   (SELECT_WIDTH),
            .COLLISION_MODE (COLLISION_MODE),
            .ROW            (k)
        ) u_wrprio (
            .wren_i      (wren_eff),
            .wraddr_i    (bus.wraddr),
            .hit_o       (hit_w[k]),
            .winner_o    (winner_w[k]),
            .collision_o (coll_w[k])
        );
    end

    // Sweep sequencing: clear in IDLE starts a wipe from row 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST_ROW) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and sweep row counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Table update: sweep wipe or winning write per row.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int k = 0; k < RAM_DEPTH; k++) entry_q[k] <= '0;
        end else begin
            for (int k = 0; k < RAM_DEPTH; k++) begin
                if (state_q == SWEEP && cnt_q == ADDR_WIDTH'(k)) begin
                    entry_q[k] <= '0;
                end else if (hit_w[k]) begin
                    entry_q[k] <= '{written: 1'b1, owner: winner_w[k]};
                end
            end
        end
    end

    // Lookup per read agent; out-of-range rows match nothing and read as {0,0}.
    always_comb begin
        rdselect_d  = '0;
        rdwritten_d = '0;
        for (int r = 0; r < NB_RDAGENT; r++) begin
            for (int k = 0; k < RAM_DEPTH; k++) begin
                if (bus.rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(k)) begin
                    if (BYPASS != 0 && hit_w[k]) begin
                        rdselect_d[r*SELECT_WIDTH +: SELECT_WIDTH] = winner_w[k];
                        rdwritten_d[r]                             = 1'b1;
                    end else begin
                        rdselect_d[r*SELECT_WIDTH +: SELECT_WIDTH] = entry_q[k].owner;
                        rdwritten_d[r]                             = entry_q[k].written;
                    end
                end
            end
            if (state_q == SWEEP) rdwritten_d[r] = 1'b0;
        end
    end

    // Registered responses; data holds when an agent makes no request.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdvalid_q   <= '0;
            rdselect_q  <= '0;
            rdwritten_q <= '0;
            wrcoll_q    <= 1'b0;
        end else begin
            rdvalid_q <= bus.rden;
            wrcoll_q  <= |coll_w;
            for (int r = 0; r < NB_RDAGENT; r++) begin
                if (bus.rden[r]) begin
                    rdselect_q[r*SELECT_WIDTH +: SELECT_WIDTH] <= rdselect_d[r*SELECT_WIDTH +: SELECT_WIDTH];
                    rdwritten_q[r] <= rdwritten_d[r];
                end
            end
        end
    end

    assign bus.busy        = (state_q == SWEEP);
    assign bus.rdvalid     = rdvalid_q;
    assign bus.rdselect    = rdselect_q;
    assign bus.rdwritten   = rdwritten_q;
    assign bus.wrcollision = wrcoll_q;

endmodule
